// File: rtl/servo_pkg.sv
// Shared constants and types for the servo angle path: the waypoint
// sequencer and the slew-limited angle stage both import this package.
package servo_pkg;

    localparam logic [7:0] ANG_MAX = 8'd180;  // mechanical travel limit, degrees
    localparam logic [7:0] ANG_RST = 8'd60;   // slewer reset angle
    localparam int         SPD_W   = 2;       // slew speed code width

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MOVE,
        ST_DWELL
    } state_t;

    // Limit a requested angle to the servo travel range.
    function automatic logic [7:0] clamp_angle(input logic [7:0] a);
        return (a > ANG_MAX) ? ANG_MAX : a;
    endfunction

endpackage

// File: rtl/servo_wp_sequencer_if.sv
// Host-side table/control signals plus slewer command/feedback, bundled
// for the waypoint sequencer. master = host/slewer side, slave = sequencer.
interface servo_wp_sequencer_if #(
    parameter int AW      = 3,
    parameter int DWELL_W = 24
) ();
    import servo_pkg::*;

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [7:0]         wr_angle;
    logic [SPD_W-1:0]   wr_speed;
    logic [AW-1:0]      last_idx;
    logic               loop;
    logic [DWELL_W-1:0] dwell;
    logic               start;
    logic               stop;
    logic [7:0]         cur_angle;
    logic [7:0]         tgt_angle;
    logic [SPD_W-1:0]   tgt_speed;
    logic [AW-1:0]      idx;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output wr_en, wr_addr, wr_angle, wr_speed, last_idx, loop, dwell,
               start, stop, cur_angle,
        input  tgt_angle, tgt_speed, idx, busy, done, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_angle, wr_speed, last_idx, loop, dwell,
               start, stop, cur_angle,
        output tgt_angle, tgt_speed, idx, busy, done, err
    );

endinterface

// File: rtl/servo_wp_ram.sv
// Waypoint table: DEPTH entries of {angle, speed}. Writes clamp the angle
// to the travel limit; reads are combinational so LOAD sees the pre-write
// contents of the entry during a same-cycle write.
module servo_wp_ram
    import servo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,       // active-low
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [7:0]       wr_angle,
    input  logic [SPD_W-1:0] wr_speed,
    input  logic [AW-1:0]    rd_addr,
    output logic [7:0]       rd_angle,
    output logic [SPD_W-1:0] rd_speed,
    output logic             err_set
);

    localparam int EW = 8 + SPD_W;

    logic [EW-1:0] entry_rd [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [EW-1:0] entry_reg;

            // Per-entry storage; reset puts every waypoint at the slewer rest angle.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_reg <= {ANG_RST, {SPD_W{1'b0}}};
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    entry_reg <= {clamp_angle(wr_angle), wr_speed};
                end
            end

            assign entry_rd[gi] = entry_reg;
        end
    endgenerate

    assign rd_angle = entry_rd[rd_addr][EW-1:SPD_W];
    assign rd_speed = entry_rd[rd_addr][SPD_W-1:0];
    assign err_set  = wr_en && (wr_angle > ANG_MAX);

endmodule

// File: rtl/servo_wp_sequencer.sv
// Waypoint sequencer: steps through the table, waits for the slewer to
// reach each target, dwells, then advances (optionally looping). Drives the
// slewer's angle/speed command registers.
module servo_wp_sequencer
    import servo_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int DWELL_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,   // active-low
    servo_wp_sequencer_if.slave  bus
);

    state_t             state_reg;
    logic [7:0]         tgt_angle_reg;
    logic [SPD_W-1:0]   tgt_speed_reg;
    logic [AW-1:0]      idx_reg;
    logic [DWELL_W-1:0] cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               err_reg;

    logic [7:0]         rd_angle;
    logic [SPD_W-1:0]   rd_speed;
    logic               err_set;
    logic               start_ok;

    servo_wp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .wr_angle (bus.wr_angle),
        .wr_speed (bus.wr_speed),
        .rd_addr  (idx_reg),
        .rd_angle (rd_angle),
        .rd_speed (rd_speed),
        .err_set  (err_set)
    );

    // A start is accepted only from IDLE and only if stop is not also asserted.
    assign start_ok = (state_reg == ST_IDLE) && bus.start && !bus.stop;

    // Sticky clamp flag: a new clamped write wins over the clear from start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (err_set) begin
            err_reg <= 1'b1;
        end else if (start_ok) begin
            err_reg <= 1'b0;
        end
    end

    // Sequencer FSM with registered command, index, dwell counter and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            tgt_angle_reg <= ANG_RST;
            tgt_speed_reg <= '0;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (bus.stop && (state_reg != ST_IDLE)) begin
                // Freeze the servo where it currently is.
                state_reg     <= ST_IDLE;
                busy_reg      <= 1'b0;
                tgt_angle_reg <= bus.cur_angle;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start_ok) begin
                            state_reg <= ST_LOAD;
                            idx_reg   <= '0;
                            busy_reg  <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        tgt_angle_reg <= rd_angle;
                        tgt_speed_reg <= rd_speed;
                        state_reg     <= ST_MOVE;
                    end
                    ST_MOVE: begin
                        if (bus.cur_angle == tgt_angle_reg) begin
                            state_reg <= ST_DWELL;
                            cnt_reg   <= '0;
                        end
                    end
                    ST_DWELL: begin
                        // >= covers dwell being lowered below the running count.
                        if (cnt_reg >= bus.dwell) begin
                            if (idx_reg < bus.last_idx) begin
                                idx_reg   <= idx_reg + AW'(1);
                                state_reg <= ST_LOAD;
                            end else if ((idx_reg == bus.last_idx) && bus.loop) begin
                                idx_reg   <= '0;
                                state_reg <= ST_LOAD;
                            end else begin
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + DWELL_W'(1);
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tgt_angle = tgt_angle_reg;
    assign bus.tgt_speed = tgt_speed_reg;
    assign bus.idx       = idx_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_servo_wp_sequencer.sv
// Directed bench for the waypoint sequencer. A 1 deg/cycle slewer model
// drives cur_angle from the commanded tgt_angle.
module tb_servo_wp_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    servo_wp_sequencer_if #(.AW(3), .DWELL_W(24)) bus ();

    servo_wp_sequencer #(
        .DEPTH   (8),
        .AW      (3),
        .DWELL_W (24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; then the slewer model moves one degree toward the command.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.cur_angle < bus.tgt_angle)
            bus.cur_angle = bus.cur_angle + 8'd1;
        else if (bus.cur_angle > bus.tgt_angle)
            bus.cur_angle = bus.cur_angle - 8'd1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] ang, input logic [1:0] spd);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = a;
        bus.wr_angle = ang;
        bus.wr_speed = spd;
        tick();
        bus.wr_en = 1'b0;
        $display("write entry %0d angle=%0d speed=%0d", a, ang, spd);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        $display("start pulse idx=%0d busy=%0d", bus.idx, bus.busy);
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        $display("stop pulse tgt_angle=%0d busy=%0d", bus.tgt_angle, bus.busy);
    endtask

    task automatic wait_cur(input string tag, input logic [7:0] v);
        int n = 0;
        while (bus.cur_angle != v && n < 400) begin
            tick();
            n++;
        end
        check(tag, bus.cur_angle, v);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 1000) begin
            tick();
            n++;
        end
        check(tag, bus.busy, 0);
    endtask

    initial begin
        int          seq[$];
        int          exp_seq[4];
        logic        saw_done;
        logic [7:0]  c;
        int          n;

        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_angle  = '0;
        bus.wr_speed  = '0;
        bus.last_idx  = '0;
        bus.loop      = 1'b0;
        bus.dwell     = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.cur_angle = 8'd60;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tgt_angle", bus.tgt_angle, 60);
        check("rst_tgt_speed", bus.tgt_speed, 0);
        check("rst_idx", bus.idx, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b1;
        tick();

        // Two-waypoint non-looping run
        wr(3'd0, 8'd90, 2'd1);
        wr(3'd1, 8'd30, 2'd3);
        bus.last_idx = 3'd1;
        bus.dwell    = 24'd4;
        bus.loop     = 1'b0;
        pulse_start();
        check("start_busy", bus.busy, 1);
        check("start_tgt_hold", bus.tgt_angle, 60);
        check("start_idx", bus.idx, 0);
        tick();
        check("load0_angle", bus.tgt_angle, 90);
        check("load0_speed", bus.tgt_speed, 1);
        wait_cur("reach_90", 8'd90);
        // Arrival edge plus dwell=4 keeps DWELL for 5 edges; the 6th edge advances.
        repeat (5) tick();
        check("dwell0_idx_hold", bus.idx, 0);
        check("dwell0_tgt_hold", bus.tgt_angle, 90);
        tick();
        check("adv_idx1", bus.idx, 1);
        check("adv_busy", bus.busy, 1);
        tick();
        check("load1_angle", bus.tgt_angle, 30);
        check("load1_speed", bus.tgt_speed, 3);
        wait_cur("reach_30", 8'd30);
        repeat (5) tick();
        check("done_early", bus.done, 0);
        tick();
        check("done_pulse", bus.done, 1);
        check("done_idx", bus.idx, 1);
        check("done_busy", bus.busy, 0);
        tick();
        check("done_one_cycle", bus.done, 0);

        // Reset mid-MOVE clears outputs and table
        bus.last_idx = 3'd0;
        pulse_start();
        tick();
        repeat (5) tick();
        check("premove_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        check("midrst_tgt_angle", bus.tgt_angle, 60);
        check("midrst_tgt_speed", bus.tgt_speed, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_idx", bus.idx, 0);
        bus.cur_angle = 8'd60;
        bus.dwell     = 24'd0;
        tick();
        tick();
        rst = 1'b1;
        pulse_start();
        tick();
        check("cleared_angle", bus.tgt_angle, 60);
        check("cleared_speed", bus.tgt_speed, 0);
        tick();
        tick();
        check("cleared_done", bus.done, 1);

        // Looping run, then stop mid-move
        wr(3'd0, 8'd90, 2'd1);
        wr(3'd1, 8'd30, 2'd3);
        bus.last_idx = 3'd1;
        bus.loop     = 1'b1;
        bus.dwell    = 24'd2;
        pulse_start();
        saw_done = 1'b0;
        seq.push_back(int'(bus.idx));
        n = 0;
        while (seq.size() < 4 && n < 2000) begin
            tick();
            n++;
            if (bus.done) saw_done = 1'b1;
            if (int'(bus.idx) != seq[$]) seq.push_back(int'(bus.idx));
        end
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
        check("loop_seq_len", seq.size(), 4);
        for (int i = 0; i < 4; i++)
            check("loop_seq_idx", (i < seq.size()) ? seq[i] : 7, exp_seq[i]);
        wait_cur("reach_47", 8'd47);
        pulse_stop();
        check("stop_tgt_angle", bus.tgt_angle, 47);
        check("stop_tgt_speed", bus.tgt_speed, 3);
        check("stop_busy", bus.busy, 0);
        check("stop_no_done", bus.done, 0);
        check("loop_no_done", saw_done, 0);
        bus.loop = 1'b0;

        // Clamp and sticky error
        wr(3'd0, 8'd200, 2'd2);
        check("err_set", bus.err, 1);
        repeat (3) tick();
        check("err_sticky", bus.err, 1);
        bus.last_idx = 3'd0;
        bus.dwell    = 24'd0;
        pulse_start();
        check("err_clear_on_start", bus.err, 0);
        check("clamp_busy", bus.busy, 1);
        tick();
        check("clamp_angle", bus.tgt_angle, 180);
        check("clamp_speed", bus.tgt_speed, 2);
        wait_idle("clamp_run_idle");

        // start+stop together in IDLE, and start while busy
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("startstop_busy", bus.busy, 0);
        check("startstop_tgt", bus.tgt_angle, 180);
        tick();
        check("startstop_busy2", bus.busy, 0);
        wr(3'd1, 8'd30, 2'd0);
        bus.last_idx = 3'd1;
        bus.dwell    = 24'd50;
        pulse_start();
        n = 0;
        while (bus.idx != 3'd1 && n < 500) begin
            tick();
            n++;
        end
        check("busy_reach_idx1", bus.idx, 1);
        pulse_start();
        check("restart_ignored_idx", bus.idx, 1);
        check("restart_ignored_busy", bus.busy, 1);
        check("restart_ignored_tgt", bus.tgt_angle, 30);
        repeat (4) tick();
        c = bus.cur_angle;
        pulse_stop();
        check("stop2_busy", bus.busy, 0);
        check("stop2_tgt", bus.tgt_angle, c);

        // Zero dwell, waypoints equal to current angle: 3 cycles per waypoint
        c = bus.cur_angle;
        wr(3'd0, c, 2'd1);
        wr(3'd1, c, 2'd2);
        bus.last_idx = 3'd1;
        bus.loop     = 1'b1;
        bus.dwell    = 24'd0;
        pulse_start();
        tick();
        check("fast_load0_speed", bus.tgt_speed, 1);
        tick();
        check("fast_idx_t3", bus.idx, 0);
        tick();
        check("fast_idx_t4", bus.idx, 1);
        tick();
        tick();
        check("fast_idx_t6", bus.idx, 1);
        check("fast_load1_speed", bus.tgt_speed, 2);
        tick();
        check("fast_idx_t7", bus.idx, 0);
        pulse_stop();
        check("fast_stop_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
